dbus_responder: RTL



---
 rtl/dbus_pkg.sv | 22 ++
 rtl/dbus_ram.sv | 42 ++++
 rtl/dbus_responder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dbus_pkg.sv
// Shared types and helpers for the data-bus responder: FSM state encoding,
// bus width and the address-window decode.
package dbus_pkg;

    localparam int DW = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WAIT  = 2'd2,
        S_REPLY = 2'd3
    } state_e;

    // Evaluated in 17 bits so a window ending at the top of the address space does not wrap.
    function automatic logic in_window(input logic [DW-1:0] addr, input logic [DW-1:0] base,
                                       input int aw);
        logic [DW:0] lim;
        lim = {1'b0, base} + (17'd1 << (aw + 1));
        return (addr >= base) && ({1'b0, addr} < lim);
    endfunction

endpackage

// File: rtl/dbus_ram.sv
// Word RAM with per-byte write enables and a registered read port whose
// output register doubles as the responder's dbi register.
module dbus_ram
    import dbus_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ce_i,
    input  logic          we_i,
    input  logic [1:0]    be_i,
    input  logic          re_i,
    input  logic          rclr_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (ce_i && we_i) begin
            if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
            if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
        end
    end

    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (ce_i) begin
            if (rclr_i)    rdata_q <= '0;
            else if (re_i) rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dbus_responder.sv
// Bus-slave responder: decodes an address window, counts wait states and
// performs one RAM access per data strobe, replying with rply/dbi.
module dbus_responder
    import dbus_pkg::*;
#(
    parameter logic [15:0] BASE = 16'o160000,
    parameter int          AW   = 8,
    parameter int          WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        sync,
    input  logic        din,
    input  logic        dout,
    input  logic        wtbt,
    input  logic [15:0] dba,
    input  logic [15:0] dbo,
    output logic [15:0] dbi,
    output logic        rply,
    output logic        sel
);

    state_e      state_q, state_d;
    logic [AW:0] addr_q, addr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sel_q, sel_d;
    logic        rply_q, rply_d;
    logic        ram_we, ram_re, ram_clr;
    logic [1:0]  ram_be;
    logic        hit;

    assign hit = in_window(dba, BASE, AW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            rply_q  <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            rply_q  <= rply_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!sync) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (hit) state_d = S_ADDR;
                S_ADDR:  if (din ^ dout) state_d = (WAIT == 0) ? S_REPLY : S_WAIT;
                S_WAIT:  if (cnt_q <= 4'd1) state_d = S_REPLY;
                S_REPLY: if (!din && !dout) state_d = S_ADDR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The RAM read is issued on the edge entering REPLY so dbi rises together with rply.
    always_comb begin
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        rply_d  = rply_q;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        ram_clr = 1'b0;
        ram_be  = wtbt ? (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
        if (!sync) begin
            sel_d   = 1'b0;
            rply_d  = 1'b0;
            ram_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_d = dba[AW:0];
                    sel_d  = hit;
                end
                S_ADDR:  if (din ^ dout) cnt_d = 4'(WAIT);
                S_WAIT:  cnt_d = cnt_q - 4'd1;
                S_REPLY: begin
                    if (!din && !dout) begin
                        rply_d  = 1'b0;
                        ram_clr = 1'b1;
                    end
                end
                default: ;
            endcase
            if (state_d == S_REPLY && state_q != S_REPLY) begin
                rply_d = 1'b1;
                ram_we = dout;
                ram_re = !dout;
            end
        end
    end

    dbus_ram #(.AW(AW)) u_ram (
        .clk_i  (clk),
        .rst_i  (reset),
        .ce_i   (ce),
        .we_i   (ram_we),
        .be_i   (ram_be),
        .re_i   (ram_re),
        .rclr_i (ram_clr),
        .addr_i (addr_q[AW:1]),
        .wdata_i(dbo),
        .rdata_o(dbi)
    );

    assign rply = rply_q;
    assign sel  = sel_q;

endmodule
